// File: rtl/osd_evcnt_regs.sv
// rtl/osd_evcnt_regs.sv - event counter bank on the external debug register range
//
// Purpose:
//   NUM_CNT 32-bit event counters behind the reg_request/reg_ack register
//   handshake. Reading CNTi_LO captures the high half into a snapshot so that a
//   following CNTi_HI read gives a coherent 32-bit value.
//
// Register map (off = reg_addr - BASE_ADDR):
//   0        CTRL    bit0 enable, bit1 clear-all (write-only strobe), bit2 edge_mode
//   1        OVF     sticky wrap flags, write 1 to clear
//   2+2i     CNTi_LO counter[15:0], latches counter[31:16] into the snapshot
//   3+2i     CNTi_HI snapshot
//
// Optional feature macro: OSD_EVCNT_EDGE_EN (CTRL bit2 edge_mode and the
// per-input edge registers exist only when it is defined).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   event_in       per-counter event strobes
//   stall          freezes all counting while high
//   reg_request    register request, held until ack/err
//   reg_write      1 = write, 0 = read
//   reg_addr       register address
//   reg_size       access size, only 2'b00 is legal
//   reg_wdata      write data
//   reg_ack        one-cycle success pulse
//   reg_err        one-cycle error pulse
//   reg_rdata      read data, valid with reg_ack, 0 after an error

module osd_evcnt_regs #(
  parameter int unsigned NUM_CNT   = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] event_in,
  input  logic               stall,
  input  logic               reg_request,
  input  logic               reg_write,
  input  logic [15:0]        reg_addr,
  input  logic [1:0]         reg_size,
  input  logic [15:0]        reg_wdata,
  output logic               reg_ack,
  output logic               reg_err,
  output logic [15:0]        reg_rdata
);

  localparam logic [15:0] END_OFF = 16'(2 + 2 * NUM_CNT);

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  state_t state;

  logic ctrl_en;
  // Counting uses a one-cycle delayed copy of the enable so that a CTRL write
  // only affects events from the cycle after its ack cycle.
  logic en_eff;
  logic edge_bit;
  logic [NUM_CNT-1:0] ovf;

`ifdef OSD_EVCNT_EDGE_EN
  logic               edge_mode;
  logic               edge_eff;
  logic [NUM_CNT-1:0] edge_prev;
  assign edge_bit = edge_mode;
`else
  assign edge_bit = 1'b0;
`endif

  // Decode
  logic [15:0] off;
  logic        in_range;
  logic        is_cnt;
  logic        acc_ok;
  logic        take;
  logic        rd_ok;
  logic        wr_ok;
  logic        ctrl_wr;
  logic        clear_all;
  logic [NUM_CNT-1:0] ovf_clr;

  assign off       = reg_addr - BASE_ADDR;
  assign in_range  = (reg_addr >= BASE_ADDR) && (off < END_OFF);
  assign is_cnt    = (off >= 16'd2);
  assign acc_ok    = in_range && (reg_size == 2'b00) && !(reg_write && is_cnt);
  assign take      = (state == ST_IDLE) && reg_request;
  assign rd_ok     = take && acc_ok && !reg_write;
  assign wr_ok     = take && acc_ok && reg_write;
  assign ctrl_wr   = wr_ok && (off == 16'd0);
  assign clear_all = ctrl_wr && reg_wdata[1];
  assign ovf_clr   = (wr_ok && (off == 16'd1)) ? reg_wdata[NUM_CNT-1:0] : '0;

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  // Counter slices
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wrap;
  logic [NUM_CNT-1:0] lo_rd;
  logic [15:0]        cnt_lo  [NUM_CNT];
  logic [15:0]        snap_rd [NUM_CNT];

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    logic [31:0] cnt;
    logic [15:0] snap;
    logic        hit;

`ifdef OSD_EVCNT_EDGE_EN
    assign hit = event_in[gi] && !(edge_eff && edge_prev[gi]);
`else
    assign hit = event_in[gi];
`endif
    assign inc[gi]   = en_eff && !stall && hit;
    // A clear in the same cycle swallows the event, so it cannot wrap either.
    assign wrap[gi]  = inc[gi] && !clear_all && (cnt == 32'hFFFF_FFFF);
    assign lo_rd[gi] = rd_ok && (off == 16'(2 + 2 * gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt  <= '0;
        snap <= '0;
      end else begin
        if (clear_all) begin
          cnt <= '0;
        end else if (inc[gi]) begin
          cnt <= cnt + 32'd1;
        end
        // The snapshot takes the pre-increment high half, matching the low
        // half returned by the same read.
        if (clear_all) begin
          snap <= '0;
        end else if (lo_rd[gi]) begin
          snap <= cnt[31:16];
        end
      end
    end

    assign cnt_lo[gi]  = cnt[15:0];
    assign snap_rd[gi] = snap;
  end

  // Read mux
  logic [15:0] rdata_next;

  always_comb begin
    rdata_next = '0;
    if (off == 16'd0) begin
      rdata_next = {13'b0, edge_bit, 1'b0, ctrl_en};
    end else if (off == 16'd1) begin
      rdata_next[NUM_CNT-1:0] = ovf;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (off == 16'(2 + 2 * i)) rdata_next = cnt_lo[i];
        if (off == 16'(3 + 2 * i)) rdata_next = snap_rd[i];
      end
    end
  end

  // Control, flags and response FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      reg_ack   <= 1'b0;
      reg_err   <= 1'b0;
      reg_rdata <= '0;
      ctrl_en   <= 1'b0;
      en_eff    <= 1'b0;
      ovf       <= '0;
`ifdef OSD_EVCNT_EDGE_EN
      edge_mode <= 1'b0;
      edge_eff  <= 1'b0;
      edge_prev <= '0;
`endif
    end else begin
      en_eff <= ctrl_en;
      // Set wins over a simultaneous write-1-to-clear.
      ovf    <= (ovf & ~ovf_clr) | wrap;
`ifdef OSD_EVCNT_EDGE_EN
      edge_eff  <= edge_mode;
      edge_prev <= event_in;
`endif
      case (state)
        ST_IDLE: begin
          reg_ack <= 1'b0;
          reg_err <= 1'b0;
          if (reg_request) begin
            state     <= ST_RESP;
            reg_ack   <= acc_ok;
            reg_err   <= !acc_ok;
            reg_rdata <= (acc_ok && !reg_write) ? rdata_next : 16'h0000;
            if (ctrl_wr) begin
              ctrl_en <= reg_wdata[0];
`ifdef OSD_EVCNT_EDGE_EN
              edge_mode <= reg_wdata[2];
`endif
            end
          end
        end
        ST_RESP: begin
          reg_ack <= 1'b0;
          reg_err <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          reg_ack <= 1'b0;
          reg_err <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_evcnt_regs.sv
// tb/tb_osd_evcnt_regs.sv - self-checking bench for osd_evcnt_regs
module tb_osd_evcnt_regs;

  localparam int N = 4;
  localparam logic [15:0] BASE = 16'h0200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  event_in = '0;
  logic          stall = 1'b0;
  logic          reg_request = 1'b0;
  logic          reg_write = 1'b0;
  logic [15:0]   reg_addr = '0;
  logic [1:0]    reg_size = '0;
  logic [15:0]   reg_wdata = '0;
  logic          reg_ack;
  logic          reg_err;
  logic [15:0]   reg_rdata;

  always #5 clk = ~clk;

  osd_evcnt_regs #(.NUM_CNT(N), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .stall(stall),
    .reg_request(reg_request), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_size(reg_size), .reg_wdata(reg_wdata), .reg_ack(reg_ack),
    .reg_err(reg_err), .reg_rdata(reg_rdata)
  );

  int checks = 0;
  int errors = 0;
  bit rand_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: counts as plain integers, register-level CTRL copy plus
  // the effective enable that lags it by one cycle.
  logic [31:0] m_cnt [N];
  logic [31:0] m_pre [N];
  logic [15:0] m_snap [N];
  logic [N-1:0] m_ovf, m_ovf_pre, m_wrap, m_prev;
  logic m_en, m_edge, m_ctrl_en, m_ctrl_edge, m_pend;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = '0; m_pre[i] = '0; m_snap[i] = '0;
    end
    m_ovf = '0; m_ovf_pre = '0; m_wrap = '0; m_prev = '0;
    m_en = 0; m_edge = 0; m_ctrl_en = 0; m_ctrl_edge = 0; m_pend = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_ovf_pre = m_ovf;
    m_wrap = '0;
    for (int i = 0; i < N; i++) begin
      m_pre[i] = m_cnt[i];
      if (m_en && !stall && event_in[i] && !(m_edge && m_prev[i])) begin
        if (m_cnt[i] == 32'hFFFF_FFFF) m_wrap[i] = 1'b1;
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_ovf = m_ovf | m_wrap;
    m_prev = event_in;
    if (m_pend) begin
      m_en = m_ctrl_en; m_edge = m_ctrl_edge; m_pend = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rand_on) begin
      event_in = N'($urandom);
      stall = ($urandom_range(0, 7) == 0);
    end
  end

  // Called in the response cycle, after the sampling edge has been modelled.
  task automatic model_apply(input logic wr, input logic [15:0] addr, input logic [1:0] size,
                             input logic [15:0] wd, output logic ok, output logic [15:0] rd);
    int off;
    off = int'(addr) - int'(BASE);
    rd = '0;
    ok = (size == 2'b00) && (off >= 0) && (off < 2 + 2 * N) && !(wr && off >= 2);
    if (!ok) return;
    if (!wr) begin
      if (off == 0) rd = {13'b0, m_ctrl_edge, 1'b0, m_ctrl_en};
      else if (off == 1) rd = 16'(m_ovf_pre);
      else if (off % 2 == 0) begin
        rd = m_pre[(off - 2) / 2][15:0];
        m_snap[(off - 2) / 2] = m_pre[(off - 2) / 2][31:16];
      end else rd = m_snap[(off - 3) / 2];
    end else if (off == 0) begin
      m_ctrl_en = wd[0];
`ifdef OSD_EVCNT_EDGE_EN
      m_ctrl_edge = wd[2];
`endif
      m_pend = 1;
      if (wd[1]) begin
        for (int i = 0; i < N; i++) begin
          m_cnt[i] = '0; m_snap[i] = '0;
        end
      end
    end else begin
      m_ovf = m_ovf & ~(wd[N-1:0] & ~m_wrap);
    end
  endtask

  // One register access starting in an IDLE cycle; returns in the cycle after
  // the response. drop_ev clears event_in once the request has been sampled.
  task automatic bus(input string name, input logic wr, input logic [15:0] addr,
                     input logic [1:0] size, input logic [15:0] wd, input bit drop_ev,
                     output logic ack, output logic err, output logic [15:0] rd);
    logic m_ok;
    logic [15:0] m_rd;
    reg_request = 1'b1; reg_write = wr; reg_addr = addr; reg_size = size; reg_wdata = wd;
    @(negedge clk);
    if (drop_ev) event_in = '0;
    ack = reg_ack; err = reg_err; rd = reg_rdata;
    model_apply(wr, addr, size, wd, m_ok, m_rd);
    check({name, " ack"}, 32'(reg_ack), 32'(m_ok));
    check({name, " err"}, 32'(reg_err), 32'(!m_ok));
    if (!wr || !m_ok) check({name, " rdata"}, 32'(reg_rdata), 32'(m_rd));
    reg_request = 1'b0;
    @(negedge clk);
    check({name, " pulse_end"}, 32'({reg_ack, reg_err}), 32'd0);
  endtask

  task automatic set_cnt(input int idx, input logic [31:0] v);
    case (idx)
      0: force dut.g_cnt[0].cnt = v;
      1: force dut.g_cnt[1].cnt = v;
      2: force dut.g_cnt[2].cnt = v;
      default: force dut.g_cnt[3].cnt = v;
    endcase
    m_cnt[idx] = v;
    #1;
    case (idx)
      0: release dut.g_cnt[0].cnt;
      1: release dut.g_cnt[1].cnt;
      2: release dut.g_cnt[2].cnt;
      default: release dut.g_cnt[3].cnt;
    endcase
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [15:0] wd;
    logic        ack;
    logic        err;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic a, e;
    logic [15:0] d;

    tbl[0] = '{1'b0, 16'h0200, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 16'h0202, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 16'h020A, 2'b00, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[3] = '{1'b1, 16'h0202, 2'b00, 16'h1234, 1'b0, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 16'h0200, 2'b01, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[5] = '{1'b0, 16'h01FF, 2'b00, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[6] = '{1'b1, 16'h0209, 2'b00, 16'hFFFF, 1'b0, 1'b1, 16'h0000};
    tbl[7] = '{1'b0, 16'h0209, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[8] = '{1'b0, 16'h0201, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[9] = '{1'b0, 16'h0202, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset ack", 32'(reg_ack), 32'd0);
    check("reset err", 32'(reg_err), 32'd0);
    check("reset rdata", 32'(reg_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      bus($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wd, 1'b0, a, e, d);
      check($sformatf("tbl%0d ack_vec", i), 32'(a), 32'(tbl[i].ack));
      check($sformatf("tbl%0d err_vec", i), 32'(e), 32'(tbl[i].err));
      check($sformatf("tbl%0d rdata_vec", i), 32'(d), 32'(tbl[i].rd));
    end

    // Five level events
    bus("en", 1'b1, 16'h0200, 2'b00, 16'h0001, 1'b0, a, e, d);
    event_in = 4'b0001;
    repeat (5) @(negedge clk);
    event_in = '0;
    bus("cnt0_lo", 1'b0, 16'h0202, 2'b00, 16'h0, 1'b0, a, e, d);
    check("five_lo", 32'(d), 32'h0005);
    bus("cnt0_hi", 1'b0, 16'h0203, 2'b00, 16'h0, 1'b0, a, e, d);
    check("five_hi", 32'(d), 32'h0000);

    // Wrap and OVF write-1-to-clear
    set_cnt(1, 32'hFFFF_FFFE);
    event_in = 4'b0010;
    repeat (3) @(negedge clk);
    event_in = '0;
    bus("cnt1_lo", 1'b0, 16'h0204, 2'b00, 16'h0, 1'b0, a, e, d);
    check("wrap_lo", 32'(d), 32'h0001);
    bus("ovf", 1'b0, 16'h0201, 2'b00, 16'h0, 1'b0, a, e, d);
    check("wrap_ovf", 32'(d), 32'h0002);
    bus("ovf_w1c", 1'b1, 16'h0201, 2'b00, 16'h0002, 1'b0, a, e, d);
    bus("ovf2", 1'b0, 16'h0201, 2'b00, 16'h0, 1'b0, a, e, d);
    check("ovf_cleared", 32'(d), 32'h0000);

    // Coherent LO/HI while counting across the half boundary
    set_cnt(0, 32'h0001_FFFF);
    event_in = 4'b0001;
    bus("coh_lo", 1'b0, 16'h0202, 2'b00, 16'h0, 1'b0, a, e, d);
    check("coh_lo_val", 32'(d), 32'hFFFF);
    bus("coh_hi", 1'b0, 16'h0203, 2'b00, 16'h0, 1'b0, a, e, d);
    check("coh_hi_val", 32'(d), 32'h0001);
    bus("clear_ev", 1'b1, 16'h0200, 2'b00, 16'h0003, 1'b1, a, e, d);
    bus("clr_lo", 1'b0, 16'h0202, 2'b00, 16'h0, 1'b0, a, e, d);
    check("clear_lo_val", 32'(d), 32'h0000);

    // Stall freezes counting
    stall = 1'b1;
    event_in = 4'b0001;
    repeat (10) @(negedge clk);
    event_in = '0;
    stall = 1'b0;
    bus("stall_lo", 1'b0, 16'h0202, 2'b00, 16'h0, 1'b0, a, e, d);
    check("stall_lo_val", 32'(d), 32'h0000);

    bus("ctrl5", 1'b1, 16'h0200, 2'b00, 16'h0005, 1'b0, a, e, d);
    event_in = 4'b0001;
    repeat (8) @(negedge clk);
    event_in = '0;
    bus("mode_lo", 1'b0, 16'h0202, 2'b00, 16'h0, 1'b0, a, e, d);
    bus("mode_ctrl", 1'b0, 16'h0200, 2'b00, 16'h0, 1'b0, a, e, d);
`ifdef OSD_EVCNT_EDGE_EN
    bus("mode_lo2", 1'b0, 16'h0202, 2'b00, 16'h0, 1'b0, a, e, d);
    check("edge_count", 32'(d), 32'h0001);
    bus("mode_ctrl2", 1'b0, 16'h0200, 2'b00, 16'h0, 1'b0, a, e, d);
    check("edge_ctrl", 32'(d), 32'h0005);
`else
    bus("mode_lo2", 1'b0, 16'h0202, 2'b00, 16'h0, 1'b0, a, e, d);
    check("level_count", 32'(d), 32'h0008);
    bus("mode_ctrl2", 1'b0, 16'h0200, 2'b00, 16'h0, 1'b0, a, e, d);
    check("level_ctrl", 32'(d), 32'h0001);
`endif

    // Reset in the response cycle drops the ack at once
    reg_request = 1'b1; reg_write = 1'b0; reg_addr = 16'h0200; reg_size = 2'b00;
    @(negedge clk);
    check("midrst ack_before", 32'(reg_ack), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst ack_after", 32'(reg_ack), 32'd0);
    check("midrst rdata", 32'(reg_rdata), 32'd0);
    reg_request = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized phase against the model
    bus("r_en", 1'b1, 16'h0200, 2'b00, 16'h0001, 1'b0, a, e, d);
    for (int i = 0; i < N; i++) set_cnt(i, 32'hFFFF_FFC0 - 32'(i * 16));
    @(negedge clk);
    rand_on = 1'b1;
    for (int k = 0; k < 120; k++) begin
      int op;
      int c;
      op = $urandom_range(0, 17);
      c = $urandom_range(0, N - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (op < 8) begin
        bus("r_lo", 1'b0, BASE + 16'(2 + 2 * c), 2'b00, 16'h0, 1'b0, a, e, d);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus("r_hi", 1'b0, BASE + 16'(3 + 2 * c), 2'b00, 16'h0, 1'b0, a, e, d);
      end else if (op < 11) begin
        bus("r_ovf", 1'b0, BASE + 16'd1, 2'b00, 16'h0, 1'b0, a, e, d);
      end else if (op < 13) begin
        bus("r_w1c", 1'b1, BASE + 16'd1, 2'b00, 16'($urandom), 1'b0, a, e, d);
      end else if (op < 14) begin
        bus("r_ctrl", 1'b0, BASE, 2'b00, 16'h0, 1'b0, a, e, d);
      end else if (op < 15) begin
        bus("r_wctrl", 1'b1, BASE, 2'b00,
            {13'b0, 1'($urandom), 1'b0, ($urandom_range(0, 3) != 0)}, 1'b0, a, e, d);
      end else if (op < 16) begin
        bus("r_clear", 1'b1, BASE, 2'b00, 16'h0003, 1'b0, a, e, d);
      end else begin
        bus("r_bad", $urandom_range(0, 1) == 1, BASE + 16'(2 + 2 * N + $urandom_range(0, 5)),
            2'($urandom), 16'h0, 1'b0, a, e, d);
      end
    end
    rand_on = 1'b0;
    @(negedge clk);
    event_in = '0;
    stall = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_evcnt_regs.md
Name: osd_evcnt_regs

Overview:
Debug-module-local event counter bank that serves the external register range of the debug status/control interface. It consumes the reg_request/reg_ack handshake that the interface issues for addresses >= 0x0200 and returns 16-bit read data. It counts NUM_CNT single-cycle event inputs in 32-bit counters. Reads of a counter are coherent through a low-half-triggered snapshot of the high half.

Parameters:
NUM_CNT, 4, number of event counters (1..16)
BASE_ADDR, 16'h0200, first register address of this bank (must have bits [15:9] != 0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
event_in  in  NUM_CNT  per-counter event strobe, synchronous to clk, counted every cycle it is high
stall  in  1  module stall from the status/control interface; 1 freezes all counting
reg_request  in  1  register request; held high until ack/err is seen
reg_write  in  1  1 = write, 0 = read
reg_addr  in  16  register address
reg_size  in  2  access size; only 2'b00 (16 bit) is legal
reg_wdata  in  16  write data
reg_ack  out  1  one-cycle success pulse
reg_err  out  1  one-cycle error pulse; never high together with reg_ack
reg_rdata  out  16  read data, valid in the reg_ack cycle

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: reg_ack=0, reg_err=0, reg_rdata=0, all counters=0, CTRL=0, OVF=0, snapshots=0, FSM=IDLE.
- Address decode uses off = reg_addr - BASE_ADDR (16-bit).
- Register map:
  - off 0 CTRL: bit0 = enable (RW). bit1 = clear-all (write 1 = clear all counters and snapshots; reads 0). bit2 = see optional feature. Other bits read 0.
  - off 1 OVF: bit i = sticky wrap flag of counter i. Write 1 to clear.
  - off 2+2i CNTi_LO: read returns counter[15:0] and latches counter[31:16] into snap[i] in the same cycle.
  - off 3+2i CNTi_HI: read returns snap[i].
  - Writes to any CNT register, off >= 2+2*NUM_CNT, addr < BASE_ADDR, or reg_size != 2'b00 produce reg_err with no state change.
- FSM has two states, IDLE and RESP.
  - IDLE: if reg_request=1, decode and perform the access, register rdata/ack/err, and go to RESP.
  - RESP: drive reg_ack or reg_err high for exactly this cycle, then go to IDLE unconditionally. Requests are ignored in RESP.
- Latency: ack/err is asserted exactly 1 cycle after the first cycle reg_request is high.
- The requester drops reg_request in the cycle after ack, so IDLE sees reg_request=0 and there is no double service.
- A request that is still high on return to IDLE is serviced as a new access.
- reg_rdata holds its last value outside ack cycles. It is 0 on error.
- Counting: counter i increments by 1 in every cycle with enable=1, stall=0 and event_in[i]=1.
  - 0xFFFF_FFFF wraps to 0 and sets OVF[i].
- Simultaneous events:
  - Clear-all write and an event in the same cycle: the counter becomes 0; the event is lost.
  - OVF W1C and a new wrap of the same counter in the same cycle: the flag stays set (set wins).
  - CNTi_LO read and an increment in the same cycle: the pre-increment value is returned, and the snapshot holds the pre-increment high half.
- A write to CTRL.enable takes effect for events from the cycle after the ack cycle onward.
- Reset mid-access (rst_n low in RESP) drops ack/err at once. No response is owed after reset.

Optional Feature:
Macro OSD_EVCNT_EDGE_EN.
- Defined: CTRL bit2 = edge_mode (RW, reset 0).
  - With edge_mode=1, a counter increments only on a 0->1 transition of event_in[i], detected against a per-input register reset to 0.
  - The edge registers update every cycle, even when stall=1 or enable=0.
- Not defined: CTRL bit2 reads 0 and writes are ignored; level mode only, and there are no edge registers.

Test Plan:
1. Reset, then read BASE_ADDR+0 -> reg_ack one cycle after request, reg_rdata=0x0000. Read off 2 -> 0x0000.
2. Write CTRL=0x0001, hold event_in[0]=1 for 5 cycles with stall=0 -> CNT0_LO reads 0x0005, CNT0_HI reads 0x0000.
3. Force counter1=0xFFFF_FFFE, enable, give 3 events -> CNT1_LO=0x0001, OVF reads 0x0002. Write OVF=0x0002 -> OVF reads 0x0000.
4. Error cases, each -> reg_err pulse, reg_ack=0, no state change:
   - read off 2+2*NUM_CNT (0x020A for NUM_CNT=4)
   - write 0x1234 to off 2
   - read with reg_size=2'b01
5. Counter0=0x0001_FFFF with events continuing, read LO then HI -> LO=0xFFFF, HI=0x0001, even though the counter has since crossed to 0x0002_xxxx. Clear-all write coincident with an event -> LO reads 0x0000.
6. stall=1 with enable=1 and 10 events -> count unchanged. With OSD_EVCNT_EDGE_EN, CTRL=0x0005 and event_in held high for 8 cycles -> count +1.
